// File: rtl/brm_rate_mult_if.sv
// Bus bundle for brm_rate_mult: enable, rate programming and pulse outputs.
// Optional BRM_PULSE_COUNT_EN adds the pulse_total output.
interface brm_rate_mult_if #(
  parameter int WIDTH = 8
);
  logic             p_0;
  logic [WIDTH-1:0] rate_in;
  logic             rate_load;
  logic             z;
  logic             period_done;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] rate_active;
  logic             rate_pending;
`ifdef BRM_PULSE_COUNT_EN
  logic [WIDTH-1:0] pulse_total;

  modport master (
    output p_0, rate_in, rate_load,
    input  z, period_done, cnt, rate_active, rate_pending, pulse_total
  );
  modport slave (
    input  p_0, rate_in, rate_load,
    output z, period_done, cnt, rate_active, rate_pending, pulse_total
  );
`else
  modport master (
    output p_0, rate_in, rate_load,
    input  z, period_done, cnt, rate_active, rate_pending
  );
  modport slave (
    input  p_0, rate_in, rate_load,
    output z, period_done, cnt, rate_active, rate_pending
  );
`endif
endinterface

// File: rtl/brm_rate_mult.sv
// Parametrised binary rate multiplier: `rate` pulses per 2^WIDTH enabled cycles,
// with period-boundary rate update. Optional macro BRM_PULSE_COUNT_EN adds pulse_total.
module brm_rate_mult #(
  parameter int WIDTH = 8
) (
  input  logic           blif_clk_net,
  input  logic           blif_reset_net,
  brm_rate_mult_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] rate_active_r;
  logic [WIDTH-1:0] shadow_r;
  logic             rate_pending_r;
  logic             fresh_r;
  logic             z_r;
  logic             period_done_r;

  logic [WIDTH-1:0] cnt_inc_s;
  logic [WIDTH-1:0] low_zero_s;
  logic [WIDTH-1:0] rate_rev_s;
  logic             wrap_s;
  logic             pulse_s;

  // Pulse select: the lowest zero bit of cnt (index = trailing ones) picks rate bit WIDTH-1-t
  always_comb begin
    cnt_inc_s  = cnt_r + CNT_ONE;
    low_zero_s = cnt_inc_s & ~cnt_r;
    for (int i = 0; i < WIDTH; i++) begin
      rate_rev_s[i] = rate_active_r[WIDTH-1-i];
    end
    wrap_s  = bus.p_0 & (cnt_r == CNT_MAX);
    pulse_s = bus.p_0 & (|(low_zero_s & rate_rev_s));
  end

  // Counter, strobes, fresh flag and shadow/active rate registers
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      cnt_r          <= {WIDTH{1'b0}};
      rate_active_r  <= {WIDTH{1'b0}};
      shadow_r       <= {WIDTH{1'b0}};
      rate_pending_r <= 1'b0;
      fresh_r        <= 1'b1;
      z_r            <= 1'b0;
      period_done_r  <= 1'b0;
    end else begin
      z_r           <= pulse_s;
      period_done_r <= wrap_s;

      if (bus.p_0) begin
        cnt_r <= cnt_inc_s;
      end else begin
        cnt_r <= cnt_r;
      end

      if (wrap_s) begin
        fresh_r <= 1'b1;
      end else if (bus.p_0) begin
        fresh_r <= 1'b0;
      end else begin
        fresh_r <= fresh_r;
      end

      // A load may only reach rate_active at a period boundary or before the first enable of a period
      if (bus.rate_load && wrap_s) begin
        rate_active_r  <= bus.rate_in;
        rate_pending_r <= 1'b0;
      end else if (bus.rate_load && fresh_r && !bus.p_0) begin
        rate_active_r  <= bus.rate_in;
      end else if (bus.rate_load) begin
        shadow_r       <= bus.rate_in;
        rate_pending_r <= 1'b1;
      end else if (wrap_s && rate_pending_r) begin
        rate_active_r  <= shadow_r;
        rate_pending_r <= 1'b0;
      end else begin
        rate_active_r  <= rate_active_r;
        rate_pending_r <= rate_pending_r;
      end
    end
  end

  assign bus.z            = z_r;
  assign bus.period_done  = period_done_r;
  assign bus.cnt          = cnt_r;
  assign bus.rate_active  = rate_active_r;
  assign bus.rate_pending = rate_pending_r;

`ifdef BRM_PULSE_COUNT_EN
  logic [WIDTH-1:0] pulse_cnt_r;
  logic [WIDTH-1:0] pulse_total_r;

  // Per-period pulse tally, published at the wrap (the wrap cycle itself never pulses)
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      pulse_cnt_r   <= {WIDTH{1'b0}};
      pulse_total_r <= {WIDTH{1'b0}};
    end else if (wrap_s) begin
      pulse_cnt_r   <= {WIDTH{1'b0}};
      pulse_total_r <= pulse_cnt_r;
    end else if (pulse_s) begin
      pulse_cnt_r   <= pulse_cnt_r + CNT_ONE;
    end else begin
      pulse_cnt_r   <= pulse_cnt_r;
    end
  end

  assign bus.pulse_total = pulse_total_r;
`endif

endmodule
